// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: icache/dcache request side and memory side of the shared memory bus.
interface mem_bus_arbiter_if;
    logic [1:0]  Imem_command;
    logic [63:0] Imem_addr;
    logic [1:0]  Dmem_command;
    logic [63:0] Dmem_addr;
    logic [63:0] Dmem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  Imem2proc_response;
    logic [3:0]  Dmem2proc_response;
    logic [3:0]  Imem2proc_tag;
    logic [3:0]  Dmem2proc_tag;
    logic [63:0] mem2proc_data_out;
    logic        grant_d;

    modport slave (
        input  Imem_command, Imem_addr, Dmem_command, Dmem_addr, Dmem_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag,
               mem2proc_data_out, grant_d
    );

    modport master (
        output Imem_command, Imem_addr, Dmem_command, Dmem_addr, Dmem_data,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               Imem2proc_response, Dmem2proc_response, Imem2proc_tag, Dmem2proc_tag,
               mem2proc_data_out, grant_d
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: dcache-priority memory bus arbiter with tag-owner tracking for returns.
// Define MEM_ARB_STARVE_EN to let a starved icache win after STARVE_LIMIT lost cycles.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic             clock,
    input logic             reset,
    mem_bus_arbiter_if.slave bus
);
    logic        i_valid, d_valid, d_win, i_win, starve;
    logic        accept_load, ret_hit;
    logic [15:0] owner_valid, owner_d;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    assign i_valid = bus.Imem_command == 2'd1;
    assign d_valid = bus.Dmem_command == 2'd1 || bus.Dmem_command == 2'd2;
    assign d_win   = d_valid && !starve;
    assign i_win   = i_valid && !d_win;

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    assign starve = i_valid && starve_cnt >= 4'(STARVE_LIMIT);
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            starve_cnt <= '0;
        else
            starve_cnt <= (i_valid && !i_win) ? (starve_cnt == 4'hF ? starve_cnt : starve_cnt + 4'd1) : '0;
`else
    assign starve = 1'b0;
`endif

    assign bus.grant_d            = d_win;
    assign bus.proc2mem_command   = d_win ? bus.Dmem_command : i_win ? 2'd1 : 2'd0;
    assign bus.proc2mem_addr      = d_win ? bus.Dmem_addr : i_win ? bus.Imem_addr : 64'd0;
    assign bus.proc2mem_data      = d_win ? bus.Dmem_data : 64'd0;
    assign bus.Dmem2proc_response = d_win ? bus.mem2proc_response : 4'd0;
    assign bus.Imem2proc_response = i_win ? bus.mem2proc_response : 4'd0;
    assign bus.mem2proc_data_out  = bus.mem2proc_data;

    // Returns are routed only for tags we recorded; unknown tags are dropped.
    assign ret_hit           = bus.mem2proc_tag != 4'd0 && owner_valid[bus.mem2proc_tag];
    assign bus.Dmem2proc_tag = (ret_hit && owner_d[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;
    assign bus.Imem2proc_tag = (ret_hit && !owner_d[bus.mem2proc_tag]) ? bus.mem2proc_tag : 4'd0;

    assign accept_load = bus.mem2proc_response != 4'd0 && (d_win ? bus.Dmem_command == 2'd1 : i_win);

    // The accept update is written last so a same-cycle re-accept overrides the return clear.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            owner_valid <= '0;
            owner_d     <= '0;
        end else begin
            if (ret_hit)
                owner_valid[bus.mem2proc_tag] <= 1'b0;
            if (accept_load) begin
                owner_valid[bus.mem2proc_response] <= 1'b1;
                owner_d[bus.mem2proc_response]     <= d_win;
            end
        end
endmodule
